// File: rtl/reduction_pkg.sv
// ============================================================================
// Package     : reduction_pkg
// Description : Op encodings, FSM states and helpers for the reduction sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reduction_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_inverting(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

  // AND-family folds start from the identity 1, the others from 0
  function automatic logic acc_init(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reduction_unit.sv
// ============================================================================
// Module      : reduction_unit
// Description : Combinational AND/OR/XOR reduction of one WIDTH-bit word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduction_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_data,
  output logic             and_r,
  output logic             or_r,
  output logic             xor_r
);

  assign and_r = &in_data;
  assign or_r  = |in_data;
  assign xor_r = ^in_data;

endmodule

`default_nettype wire

// File: rtl/reduction_seq_ctrl.sv
// ============================================================================
// Module      : reduction_seq_ctrl
// Description : Command-driven packet reduction with in/result handshakes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduction_seq_ctrl
  import reduction_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 8,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             res_ready,
  output logic             res_valid,
  output logic             res,
  output logic             busy,
  output logic             err
);

  state_t           r_state;
  logic [2:0]       r_op;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic             r_acc;
  logic             r_res;
  logic             r_err;
  logic             r_in_ready;
  logic             r_res_valid;
  logic             r_busy;

  logic             w_and;
  logic             w_or;
  logic             w_xor;
  logic             w_acc_next;
  logic             w_cmd_ok;

  reduction_unit #(.WIDTH(WIDTH)) u_unit (
    .in_data (in_data),
    .and_r   (w_and),
    .or_r    (w_or),
    .xor_r   (w_xor)
  );

  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_AND, OP_NAND: w_acc_next = r_acc & w_and;
      OP_OR,  OP_NOR:  w_acc_next = r_acc | w_or;
      OP_XOR, OP_XNOR: w_acc_next = r_acc ^ w_xor;
      default:         w_acc_next = r_acc;
    endcase
  end

  assign w_cmd_ok = op_legal(op) && (len >= LEN_W'(1)) && (len <= LEN_W'(MAX_WORDS));

  // Handshake outputs are registered alongside the state so they always match it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_AND;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= 1'b0;
      r_res       <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cmd_ok) begin
              r_op       <= op;
              r_len      <= len;
              r_count    <= '0;
              r_acc      <= acc_init(op);
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_ACCUM;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + LEN_W'(1);
            if (r_count == r_len - LEN_W'(1)) begin
              r_res       <= w_acc_next ^ is_inverting(r_op);
              r_in_ready  <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign res       = r_res;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: doc/reduction_seq_ctrl.md
Name: reduction_seq_ctrl

Overview:
Sequenced controller around the team's combinational reduction datapath (&, |, ^ and their inverses over a WIDTH-bit vector). It accepts a command (op, length) and streams a packet of words through a valid/ready handshake. It folds each word's reduction into a 1-bit accumulator and presents a single packet-level result with its own valid/ready handshake. It sits between a word source and any consumer of packet parity or all-ones/any-ones status.

Parameters:
WIDTH, 4, bits per input word
MAX_WORDS, 8, maximum packet length in words
LEN_W, $clog2(MAX_WORDS+1), width of the len field (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
op  in  3  0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR; 6,7 illegal
len  in  LEN_W  packet length in words, legal range 1..MAX_WORDS
in_valid  in  1  input word valid
in_data  in  WIDTH  input word
in_ready  out  1  block accepts a word this cycle
res_ready  in  1  consumer accepts the result
res_valid  out  1  result valid
res  out  1  packet reduction result
busy  out  1  high in ACCUM and DONE
err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset: synchronous, active-high, clk only. Next edge forces state=IDLE. in_ready=0, res_valid=0, res=0, busy=0, err=0, count=0, acc=0. Reset mid-packet discards the partial accumulation with no result.
- States: IDLE, ACCUM, DONE. Registered state; outputs decoded from state. res is a register.
- IDLE, start=1, op<=5, 1<=len<=MAX_WORDS:
  - latch op and len; count=0
  - acc=1 for AND/NAND; acc=0 for OR/NOR/XOR/XNOR
  - go to ACCUM
- IDLE, start=1 with illegal op, len=0, or len>MAX_WORDS: err=1 for exactly one cycle. Stay IDLE; latched fields unchanged.
- start is ignored outside IDLE. No err is raised in that case.
- ACCUM:
  - in_ready=1.
  - Word accepted iff in_valid&in_ready. On accept, compute the word reduction r from the base op (AND/NAND use &, OR/NOR use |, XOR/XNOR use ^):
    - AND/NAND: acc = acc & r
    - OR/NOR: acc = acc | r
    - XOR/XNOR: acc = acc ^ r
  - count++ on each accept.
  - Accept while count==len-1: go to DONE. res = acc_next, inverted for NAND/NOR/XNOR.
  - in_valid gaps hold state and acc.
- DONE:
  - res_valid=1, in_ready=0, res stable.
  - res_valid & res_ready: go to IDLE. res_valid drops next cycle; res keeps its value until the next result.
- Latency:
  - res_valid asserts on the cycle after the edge that accepts the last word.
  - Minimum packet of 1 word: start edge, accept edge, then result visible.
  - Back-to-back: start may be asserted the cycle after the DONE→IDLE handshake.
- Simultaneous events: rst has priority over everything. In IDLE, start with in_valid=1 does not consume a word.

Decomposition:
- Package reduction_pkg:
  - op encodings: OP_AND..OP_XNOR as localparams
  - state encoding
  - function is_inverting(op)
  - function op_legal(op)
- Sub-module reduction_unit (combinational, parameter WIDTH): in_data → and_r, or_r, xor_r. This is the existing datapath, instantiated once.
- Controller FSM, counter and accumulator live in reduction_seq_ctrl.

Test Plan:
1. AND, len=3, words 1111,1111,1111 → res=1. Then AND, len=2, words 1111,1110 → res=0. NAND on the second packet → res=1.
2. XOR, len=4, words 0001,0011,0101,0111 (reductions 1,0,0,1) → res=0. XNOR on the same words → res=1. res_valid rises exactly 1 cycle after the 4th accept.
3. NOR, len=2, words 0000,0000 → res=1. OR on the same words → res=0. OR, len=2, words 0000,0100 → res=1.
4. Backpressure and gaps:
   - in_valid low 3 cycles between words → result unchanged.
   - res_ready low 5 cycles in DONE → res_valid and res held, in_ready=0.
   - start pulsed during DONE → ignored, no err.
5. Rejected commands: start with op=6, then start with len=0, then start with len=9 (MAX_WORDS=8) → err high 1 cycle each, busy=0 throughout, in_ready=0.
6. rst asserted after 2 of 4 words of an XOR packet → next cycle all outputs 0, state IDLE. A fresh XOR, len=1, word 0111 → res=1.
